eccop_job_sched: RTL and testbench

Job scheduler in front of eccop_mcu. It shares the single MCU/ALU sequencer among P_NREQ requesters. Each job is a program start address. The block grants one requester at a time, drives the MCU start interface, supervises execution with a watchdog and an abort path, and returns a per-requester done pulse with a completion status.

---
 rtl/eccop_job_sched.sv | 154 +++++++++++++++
 tb/tb_eccop_job_sched.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eccop_job_sched.sv
// Round-robin job scheduler sharing one eccop_mcu sequencer; supervises each job with watchdog and abort.
// Optional ECCOP_SCHED_PRIO_EN: requester 0 becomes a high-priority lane that bypasses round-robin.
module eccop_job_sched #(
  parameter int P_NREQ         = 4,
  parameter int P_MEMSIZE_LOG2 = 9,
  parameter int P_TIMEOUT_LOG2 = 16,
  localparam int P_IDW         = (P_NREQ > 1) ? $clog2(P_NREQ) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [P_NREQ-1:0]                req_valid,
  input  logic [P_NREQ*P_MEMSIZE_LOG2-1:0] req_addr,
  output logic [P_NREQ-1:0]                req_ready,
  output logic [P_NREQ-1:0]                done,
  output logic [1:0]                       done_status,
  input  logic                             abort,
  output logic                             busy,
  output logic [P_IDW-1:0]                 busy_id,
  output logic [P_MEMSIZE_LOG2-1:0]        op_start_addr,
  output logic                             op_start_en,
  output logic                             op_start_wr,
  input  logic                             op_running
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_RUN, S_STOP, S_DONE} state_t;

  state_t                      r_state;
  logic [P_IDW-1:0]            r_rr_ptr;
  logic [P_TIMEOUT_LOG2-1:0]   r_wdog;
  logic [1:0]                  r_status;
  logic [P_NREQ-1:0]           r_done;
  logic [1:0]                  r_done_status;
  logic                        r_busy;
  logic [P_IDW-1:0]            r_busy_id;
  logic [P_MEMSIZE_LOG2-1:0]   r_op_addr;
  logic                        r_op_en;
  logic                        r_op_wr;

  logic                        w_win_vld;
  logic [P_IDW-1:0]            w_win_id;
  logic [P_IDW-1:0]            w_cand;
  logic [P_NREQ-1:0]           w_owner_oh;

  // Search starts one past the last winner so every requester is served in turn.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_id  = '0;
    w_cand    = '0;
    for (int k = 1; k <= P_NREQ; k++) begin
      w_cand = P_IDW'((int'(r_rr_ptr) + k) % P_NREQ);
`ifdef ECCOP_SCHED_PRIO_EN
      if (!w_win_vld && (w_cand != '0) && req_valid[w_cand]) begin
`else
      if (!w_win_vld && req_valid[w_cand]) begin
`endif
        w_win_vld = 1'b1;
        w_win_id  = w_cand;
      end
    end
`ifdef ECCOP_SCHED_PRIO_EN
    if (req_valid[0]) begin
      w_win_vld = 1'b1;
      w_win_id  = '0;
    end
`endif
  end

  assign req_ready   = (reset && (r_state == S_IDLE) && w_win_vld) ? (P_NREQ'(1) << w_win_id) : '0;
  assign w_owner_oh  = P_NREQ'(1) << r_busy_id;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= P_IDW'(P_NREQ - 1);
      r_wdog        <= '0;
      r_status      <= 2'b00;
      r_done        <= '0;
      r_done_status <= 2'b00;
      r_busy        <= 1'b0;
      r_busy_id     <= '0;
      r_op_addr     <= '0;
      r_op_en       <= 1'b0;
      r_op_wr       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_win_vld) begin
`ifdef ECCOP_SCHED_PRIO_EN
            if (w_win_id != '0) r_rr_ptr <= w_win_id;
`else
            r_rr_ptr <= w_win_id;
`endif
            r_busy_id <= w_win_id;
            r_op_addr <= req_addr[w_win_id*P_MEMSIZE_LOG2 +: P_MEMSIZE_LOG2];
            r_op_en   <= 1'b1;
            r_op_wr   <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_START;
          end
        end
        S_START: begin
          r_op_wr <= 1'b0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_wdog  <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          // Completion outranks abort, which outranks timeout.
          if (!op_running) begin
            r_done        <= w_owner_oh;
            r_done_status <= 2'b00;
            r_state       <= S_DONE;
          end else if (abort) begin
            r_status <= 2'b10;
            r_op_en  <= 1'b0;
            r_op_wr  <= 1'b1;
            r_state  <= S_STOP;
          end else if (&r_wdog) begin
            r_status <= 2'b01;
            r_op_en  <= 1'b0;
            r_op_wr  <= 1'b1;
            r_state  <= S_STOP;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        S_STOP: begin
          r_op_wr       <= 1'b0;
          r_done        <= w_owner_oh;
          r_done_status <= r_status;
          r_state       <= S_DONE;
        end
        S_DONE: begin
          r_done        <= '0;
          r_done_status <= 2'b00;
          r_busy        <= 1'b0;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign done          = r_done;
  assign done_status   = r_done_status;
  assign busy          = r_busy;
  assign busy_id       = r_busy_id;
  assign op_start_addr = r_op_addr;
  assign op_start_en   = r_op_en;
  assign op_start_wr   = r_op_wr;

endmodule

// File: tb/tb_eccop_job_sched.sv
// Directed bench for eccop_job_sched with a small MCU model and event logs.
module tb_eccop_job_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [35:0] req_addr;
  logic [3:0]  req_ready;
  logic [3:0]  done;
  logic [1:0]  done_status;
  logic        abort;
  logic        busy;
  logic [1:0]  busy_id;
  logic [8:0]  op_start_addr;
  logic        op_start_en;
  logic        op_start_wr;
  logic        op_running;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int mcu_cnt;
  int run_len = 1;
  bit mcu_stuck = 1'b0;

  int g_id[$], g_cyc[$];
  int w_en[$], w_addr[$], w_bid[$], w_cyc[$];
  int d_vec[$], d_st[$], d_cyc[$];

`ifdef ECCOP_SCHED_PRIO_EN
  int exp2[5] = '{0, 0, 0, 0, 0};
  int exp6[4] = '{0, 0, 0, 0};
`else
  int exp2[5] = '{0, 1, 2, 3, 0};
  int exp6[4] = '{0, 2, 0, 2};
`endif

  eccop_job_sched #(.P_NREQ(4), .P_MEMSIZE_LOG2(9), .P_TIMEOUT_LOG2(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .done(done), .done_status(done_status), .abort(abort),
    .busy(busy), .busy_id(busy_id), .op_start_addr(op_start_addr),
    .op_start_en(op_start_en), .op_start_wr(op_start_wr), .op_running(op_running)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // MCU model: runs run_len cycles after a start write, stops on a stop write.
  always @(posedge clk or negedge reset) begin
    if (!reset) mcu_cnt <= 0;
    else if (op_start_wr && op_start_en) mcu_cnt <= run_len;
    else if (op_start_wr) mcu_cnt <= 0;
    else if (mcu_cnt > 0) mcu_cnt <= mcu_cnt - 1;
  end
  assign op_running = (mcu_cnt != 0) || mcu_stuck;

  function automatic int oh2id(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      if (|(req_ready & req_valid)) begin
        g_id.push_back(oh2id(req_ready & req_valid));
        g_cyc.push_back(cyc);
      end
      if (op_start_wr) begin
        w_en.push_back(int'(op_start_en));
        w_addr.push_back(int'(op_start_addr));
        w_bid.push_back(int'(busy_id));
        w_cyc.push_back(cyc);
      end
      if (|done) begin
        d_vec.push_back(int'(done));
        d_st.push_back(int'(done_status));
        d_cyc.push_back(cyc);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    g_id.delete(); g_cyc.delete();
    w_en.delete(); w_addr.delete(); w_bid.delete(); w_cyc.delete();
    d_vec.delete(); d_st.delete(); d_cyc.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0; req_valid = '0; abort = 1'b0; mcu_stuck = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
    clear_logs();
  endtask

  // Waits for n grants, then withdraws all requests (state is past IDLE by then).
  task automatic grant_wait(input int n);
    int t = 0;
    while (g_id.size() < n && t < 200) begin tick(1); t++; end
    check("grant_timeout", g_id.size() >= n, 1);
    req_valid = '0;
  endtask

  task automatic done_wait(input int n);
    int t = 0;
    while (d_vec.size() < n && t < 200) begin tick(1); t++; end
    check("done_timeout", d_vec.size() >= n, 1);
    tick(1);
  endtask

  initial begin
    req_addr = {9'd40, 9'd30, 9'd20, 9'd10};
    req_valid = '0; abort = 1'b0; reset = 1'b0;
    tick(2);
    check("rst_ready", req_ready, 0);
    check("rst_done", done, 0);
    check("rst_status", done_status, 0);
    check("rst_busy", busy, 0);
    check("rst_busy_id", busy_id, 0);
    check("rst_addr", op_start_addr, 0);
    check("rst_en", op_start_en, 0);
    check("rst_wr", op_start_wr, 0);
    reset = 1'b1;
    tick(1);
    clear_logs();

    // 1: single job, MCU runs 5 cycles
    run_len = 5;
    req_valid = 4'b0001;
    grant_wait(1);
    check("t1_busy", busy, 1);
    done_wait(1);
    check("t1_gid", qat(g_id, 0), 0);
    check("t1_nwr", w_en.size(), 1);
    check("t1_en", qat(w_en, 0), 1);
    check("t1_addr", qat(w_addr, 0), 10);
    check("t1_wr_lat", qat(w_cyc, 0) - qat(g_cyc, 0), 1);
    check("t1_done_vec", qat(d_vec, 0), 1);
    check("t1_status", qat(d_st, 0), 0);
    check("t1_done_lat", qat(d_cyc, 0) - qat(g_cyc, 0), 8);
    check("t1_idle", busy, 0);

    // 2: all requesters valid, round-robin order
    do_reset();
    run_len = 1;
    req_valid = 4'b1111;
    grant_wait(5);
    done_wait(5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_gid%0d", i), qat(g_id, i), exp2[i]);
      check($sformatf("t2_addr%0d", i), qat(w_addr, i), 10 * (exp2[i] + 1));
      check($sformatf("t2_bid%0d", i), qat(w_bid, i), exp2[i]);
      check($sformatf("t2_done%0d", i), qat(d_vec, i), 1 << exp2[i]);
    end
    check("t2_first_lat", qat(d_cyc, 0) - qat(g_cyc, 0), 4);

    // 3: watchdog timeout with op_running stuck high
    clear_logs();
    mcu_stuck = 1'b1;
    req_valid = 4'b0001;
    grant_wait(1);
    done_wait(1);
    mcu_stuck = 1'b0;
    check("t3_nwr", w_en.size(), 2);
    check("t3_stop_en", qat(w_en, 1), 0);
    check("t3_stop_addr", qat(w_addr, 1), 10);
    check("t3_stop_lat", qat(w_cyc, 1) - qat(w_cyc, 0), 18);
    check("t3_status", qat(d_st, 0), 1);
    check("t3_done_lat", qat(d_cyc, 0) - qat(w_cyc, 1), 1);

    // 4a: abort on RUN cycle 3
    clear_logs();
    run_len = 10;
    req_valid = 4'b0001;
    grant_wait(1);
    tick(4);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    done_wait(1);
    check("t4a_nwr", w_en.size(), 2);
    check("t4a_stop_en", qat(w_en, 1), 0);
    check("t4a_stop_lat", qat(w_cyc, 1) - qat(g_cyc, 0), 6);
    check("t4a_status", qat(d_st, 0), 2);
    check("t4a_done_lat", qat(d_cyc, 0) - qat(g_cyc, 0), 7);

    // 4b: abort in the cycle op_running falls -> completion wins
    clear_logs();
    run_len = 3;
    req_valid = 4'b0001;
    grant_wait(1);
    tick(4);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    done_wait(1);
    check("t4b_nwr", w_en.size(), 1);
    check("t4b_status", qat(d_st, 0), 0);
    check("t4b_done_lat", qat(d_cyc, 0) - qat(g_cyc, 0), 6);

    // 5: reset during RUN
    clear_logs();
    run_len = 20;
    req_valid = 4'b0010;
    grant_wait(1);
    tick(3);
    reset = 1'b0;
    #1;
    check("t5_busy", busy, 0);
    check("t5_wr", op_start_wr, 0);
    check("t5_en", op_start_en, 0);
    check("t5_addr", op_start_addr, 0);
    check("t5_busy_id", busy_id, 0);
    check("t5_done", done, 0);
    tick(2);
    reset = 1'b1;
    tick(5);
    check("t5_no_done", d_vec.size(), 0);
    clear_logs();
    run_len = 1;
    req_valid = 4'b0100;
    grant_wait(1);
    done_wait(1);
    check("t5_gid", qat(g_id, 0), 2);
    check("t5_addr_slice", qat(w_addr, 0), 30);
    check("t5_done_vec", qat(d_vec, 0), 4);

    // 6: requesters 0 and 2 persistently valid
    do_reset();
    req_valid = 4'b0101;
    grant_wait(4);
    done_wait(4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t6_gid%0d", i), qat(g_id, i), exp6[i]);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
